// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the memory port arbiter and its neighbours: the fetch
// requester, the writeback data requester, the single-port memory bus, and
// the stall / error status lines.
//   slave  : arbiter view (takes requests and memory responses, drives acks,
//            the memory cycle and status).
//   master : environment view (requesters + memory model).
interface mem_port_arbiter_if;
  // fetch side
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  // data side
  logic        dm_mr;
  logic        dm_mw;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  // memory bus
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  // status
  logic        stall_req;
  logic        bus_err;

  modport slave (
    input  if_req, if_addr, dm_mr, dm_mw, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_ce, mem_we, mem_addr, mem_wdata,
           stall_req, bus_err
  );

  modport master (
    output if_req, if_addr, dm_mr, dm_mw, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_ce, mem_we, mem_addr, mem_wdata,
           stall_req, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data
// accesses. Data wins over fetch, except that after MAX_DM_STREAK back-to-back
// data grants a waiting fetch is forced through. Each memory cycle is a
// registered ce/ready handshake; a cycle that sees no mem_ready for TIMEOUT
// busy cycles is aborted, acked with 32'hDEADBEEF read data, and latches a
// sticky bus_err.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : mem_port_arbiter_if.slave -- fetch/data request+ack, memory
//              bus (ce/we/addr/wdata out, rdata/ready in), stall_req, bus_err
module mem_port_arbiter #(
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT       = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  mem_port_arbiter_if.slave        bus
);
  localparam int          SW         = $clog2(MAX_DM_STREAK + 1);
  localparam int          TW         = $clog2(TIMEOUT + 1);
  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {IDLE, DM_BUSY, IF_BUSY} state_t;

  // registered memory-cycle request, held constant while busy
  typedef struct packed {
    logic        ce;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  state_t        state_q, state_d;
  mreq_t         mreq_q, mreq_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic          err_q, err_d;

  logic          dm_pend;
  logic          if_forced;
  logic          abort;
  logic [31:0]   rd_data;

  always_comb begin
    dm_pend   = bus.dm_mr | bus.dm_mw;
    // fetch overrides data once the data streak has hit its limit
    if_forced = bus.if_req && (streak_q == SW'(MAX_DM_STREAK));
    // this busy cycle is the TIMEOUT-th one without ready
    abort     = (tmo_q == TW'(TIMEOUT - 1)) && !bus.mem_ready;
    rd_data   = bus.mem_ready ? bus.mem_rdata : ABORT_DATA;
  end

  always_comb begin
    state_d    = state_q;
    mreq_d     = mreq_q;
    streak_d   = streak_q;
    tmo_d      = tmo_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (dm_pend && !if_forced) begin
          state_d     = DM_BUSY;
          mreq_d.ce   = 1'b1;
          mreq_d.addr = bus.dm_mr ? bus.dm_addr : bus.dm_addr;
          // mr+mw together is a read
          mreq_d.we   = bus.dm_mw & ~bus.dm_mr;
          if (bus.dm_mw && !bus.dm_mr) mreq_d.wdata = bus.dm_wdata;
          if (streak_q != SW'(MAX_DM_STREAK)) streak_d = streak_q + 1'b1;
          tmo_d       = '0;
        end else if (bus.if_req) begin
          state_d     = IF_BUSY;
          mreq_d.ce   = 1'b1;
          mreq_d.we   = 1'b0;
          mreq_d.addr = bus.if_addr;
          streak_d    = '0;
          tmo_d       = '0;
        end
      end
      DM_BUSY, IF_BUSY: begin
        if (bus.mem_ready || abort) begin
          state_d   = IDLE;
          mreq_d.ce = 1'b0;
          mreq_d.we = 1'b0;
          if (state_q == DM_BUSY) begin
            dm_ack_d = 1'b1;
            if (!mreq_q.we) dm_rdata_d = rd_data;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = rd_data;
          end
          if (!bus.mem_ready) err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mreq_q     <= '0;
      streak_q   <= '0;
      tmo_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mreq_q     <= mreq_d;
      streak_q   <= streak_d;
      tmo_q      <= tmo_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      err_q      <= err_d;
    end
  end

  assign bus.mem_ce    = mreq_q.ce;
  assign bus.mem_we    = mreq_q.we;
  assign bus.mem_addr  = mreq_q.addr;
  assign bus.mem_wdata = mreq_q.wdata;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.bus_err   = err_q;
  // acks are registered, so the stall drops in the ack cycle itself
  assign bus.stall_req = (bus.if_req & ~if_ack_q) | (dm_pend & ~dm_ack_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int MAXS = 4;
  localparam int TMO  = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();
  mem_port_arbiter #(.MAX_DM_STREAK(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  // memory device (driven by DUT outputs) and the reference copy
  logic [31:0] dev_mem [256];
  logic [31:0] ref_mem [256];
  assign bus.mem_rdata = dev_mem[bus.mem_addr[9:2]];

  int n_cmp = 0, n_err = 0, cyc = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // requester work lists: kind 0 read, 1 write, 2 read+write strobes
  typedef struct { int kind; logic [31:0] addr; logic [31:0] wdata; } op_t;
  op_t         dm_q[$];
  logic [31:0] if_q[$];
  int          ack_log[$];
  int dm_t0, dm_lat, dm_ack_cyc, if_ack_cyc;
  int rdy_mode, wait_n, bc;

  // transaction-level reference: who owns the bus, what it is doing, how
  // long it has waited
  int          m_own;      // 0 none, 1 data, 2 fetch
  bit          m_wr;
  logic [31:0] m_addr, m_wdata, m_if_rd, m_dm_rd;
  int          m_wait, m_streak;
  bit          m_if_ack, m_dm_ack, m_err;
  // DUT bus state just before the edge, for the memory device
  bit          p_ce, p_we, p_rdy;
  logic [31:0] p_addr, p_wdata;

  task automatic model_reset();
    m_own = 0; m_wr = 0; m_addr = '0; m_wdata = '0; m_if_rd = '0; m_dm_rd = '0;
    m_wait = 0; m_streak = 0; m_if_ack = 0; m_dm_ack = 0; m_err = 0;
  endtask

  task automatic model_edge();
    logic [31:0] rd;
    m_if_ack = 0; m_dm_ack = 0;
    if (m_own == 0) begin
      if ((bus.dm_mr || bus.dm_mw) && !(bus.if_req && m_streak == MAXS)) begin
        m_own = 1; m_wr = bus.dm_mw && !bus.dm_mr; m_addr = bus.dm_addr;
        if (m_wr) m_wdata = bus.dm_wdata;
        m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
        m_wait = 0;
      end else if (bus.if_req) begin
        m_own = 2; m_wr = 0; m_addr = bus.if_addr; m_streak = 0; m_wait = 0;
      end
    end else if (bus.mem_ready || m_wait + 1 == TMO) begin
      rd = bus.mem_ready ? ref_mem[m_addr[9:2]] : 32'hDEADBEEF;
      if (bus.mem_ready && m_wr) ref_mem[m_addr[9:2]] = m_wdata;
      if (!bus.mem_ready) m_err = 1;
      if (m_own == 1) begin m_dm_ack = 1; if (!m_wr) m_dm_rd = rd; end
      else begin m_if_ack = 1; m_if_rd = rd; end
      m_own = 0; m_wr = 0;
    end else begin
      m_wait++;
    end
  endtask

  task automatic drive();
    if (bus.dm_ack && dm_q.size() > 0) begin
      void'(dm_q.pop_front()); ack_log.push_back(1); dm_lat = cyc - dm_t0; dm_ack_cyc = cyc;
    end
    if (dm_q.size() > 0) begin
      if (!(bus.dm_mr || bus.dm_mw) || bus.dm_ack) dm_t0 = cyc;
      bus.dm_mr = dm_q[0].kind != 1; bus.dm_mw = dm_q[0].kind != 0;
      bus.dm_addr = dm_q[0].addr; bus.dm_wdata = dm_q[0].wdata;
    end else begin
      bus.dm_mr = 0; bus.dm_mw = 0; bus.dm_addr = $urandom; bus.dm_wdata = $urandom;
    end
    if (bus.if_ack && if_q.size() > 0) begin
      void'(if_q.pop_front()); ack_log.push_back(2); if_ack_cyc = cyc;
    end
    if (if_q.size() > 0) begin bus.if_req = 1; bus.if_addr = if_q[0]; end
    else begin bus.if_req = 0; bus.if_addr = $urandom; end
    if (bus.mem_ce) bc++; else bc = 0;
    case (rdy_mode)
      0: bus.mem_ready = 1;
      1: bus.mem_ready = ($urandom_range(0, 3) != 0);
      2: bus.mem_ready = 0;
      default: bus.mem_ready = (bc == wait_n + 1);
    endcase
  endtask

  task automatic snap();
    p_ce = bus.mem_ce; p_we = bus.mem_we; p_addr = bus.mem_addr;
    p_wdata = bus.mem_wdata; p_rdy = bus.mem_ready;
  endtask

  task automatic step();
    @(posedge clk); #1; cyc++;
    if (p_ce && p_we && p_rdy) dev_mem[p_addr[9:2]] = p_wdata;
    model_edge();
    chk("mem_ce",   32'(bus.mem_ce),   32'(m_own != 0));
    chk("mem_we",   32'(bus.mem_we),   32'(m_wr));
    if (m_own != 0) chk("mem_addr", bus.mem_addr, m_addr);
    if (m_wr)       chk("mem_wdata", bus.mem_wdata, m_wdata);
    chk("if_ack",   32'(bus.if_ack),   32'(m_if_ack));
    chk("dm_ack",   32'(bus.dm_ack),   32'(m_dm_ack));
    chk("if_rdata", bus.if_rdata, m_if_rd);
    chk("dm_rdata", bus.dm_rdata, m_dm_rd);
    chk("bus_err",  32'(bus.bus_err),  32'(m_err));
    drive();
    #1;
    chk("stall_req", 32'(bus.stall_req),
        32'((bus.if_req && !m_if_ack) || ((bus.dm_mr || bus.dm_mw) && !m_dm_ack)));
    snap();
  endtask

  task automatic drain(int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (dm_q.size() == 0 && if_q.size() == 0 && m_own == 0) begin ok = 1; break; end
    end
    chk("drain_in_budget", 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin dev_mem[i] = $urandom; ref_mem[i] = dev_mem[i]; end
    bus.if_req = 0; bus.if_addr = 0; bus.dm_mr = 0; bus.dm_mw = 0;
    bus.dm_addr = 0; bus.dm_wdata = 0; bus.mem_ready = 0;
    model_reset(); snap(); rdy_mode = 0; wait_n = 0; bc = 0;
    dm_t0 = 0; dm_lat = 0; dm_ack_cyc = 0; if_ack_cyc = 0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_ce", 32'(bus.mem_ce), 0);   chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_if_rdata", bus.if_rdata, 0);    chk("rst_dm_rdata", bus.dm_rdata, 0);
    chk("rst_if_ack", 32'(bus.if_ack), 0);   chk("rst_dm_ack", 32'(bus.dm_ack), 0);
    chk("rst_bus_err", 32'(bus.bus_err), 0); chk("rst_stall", 32'(bus.stall_req), 0);
    #4 rst = 0;

    // zero-wait read
    dev_mem[4] = 32'h1234; ref_mem[4] = 32'h1234;
    dm_q.push_back('{0, 32'h10, 32'h0});
    drain(20);
    chk("zw_latency", 32'(dm_lat), 2);
    chk("zw_rdata", bus.dm_rdata, 32'h1234);

    // write with 3 wait states
    rdy_mode = 3; wait_n = 3;
    dm_q.push_back('{1, 32'h20, 32'hCAFEF00D});
    drain(20);
    chk("wr_latency", 32'(dm_lat), 5);
    chk("wr_rdata_kept", bus.dm_rdata, 32'h1234);
    chk("wr_mem", dev_mem[8], 32'hCAFEF00D);

    // simultaneous fetch and data read
    rdy_mode = 0;
    dev_mem[16] = 32'h0BADF00D; ref_mem[16] = 32'h0BADF00D;
    ack_log.delete();
    dm_q.push_back('{0, 32'h30, 32'h0});
    if_q.push_back(32'h40);
    drain(20);
    chk("sim_first_dm", 32'(ack_log[0]), 1);
    chk("sim_gap", 32'(if_ack_cyc - dm_ack_cyc), 2);
    chk("sim_if_rdata", bus.if_rdata, 32'h0BADF00D);

    // starvation limit
    ack_log.delete();
    for (int i = 0; i < 6; i++) dm_q.push_back('{0, 32'(i * 4), 32'h0});
    if_q.push_back(32'h80);
    drain(60);
    chk("starve_n_acks", 32'(ack_log.size()), 7);
    for (int i = 0; i < 7 && i < ack_log.size(); i++)
      chk("starve_order", 32'(ack_log[i]), (i == 4) ? 32'd2 : 32'd1);

    // timeout
    rdy_mode = 2;
    dm_q.push_back('{0, 32'h50, 32'h0});
    drain(40);
    chk("tmo_latency", 32'(dm_lat), 16);
    chk("tmo_rdata", bus.dm_rdata, 32'hDEADBEEF);
    chk("tmo_err", 32'(bus.bus_err), 1);
    rdy_mode = 0;
    dm_q.push_back('{1, 32'h54, 32'h5A5A5A5A});
    dm_q.push_back('{0, 32'h54, 32'h0});
    drain(20);
    chk("err_sticky", 32'(bus.bus_err), 1);
    chk("post_tmo_rd", bus.dm_rdata, 32'h5A5A5A5A);

    // randomized traffic
    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if (dm_q.size() < 2 && $urandom_range(0, 3) == 0)
        dm_q.push_back('{int'($urandom_range(0, 2)), $urandom & 32'h3FC, $urandom});
      if (if_q.size() < 2 && $urandom_range(0, 3) == 0)
        if_q.push_back($urandom & 32'h3FC);
      step();
    end
    drain(200);

    // reset during a 5-wait read
    rdy_mode = 3; wait_n = 5;
    dm_q.push_back('{0, 32'h60, 32'h0});
    repeat (3) step();
    #2 rst = 1;
    #1;
    chk("rst_mid_mem_ce", 32'(bus.mem_ce), 0);
    chk("rst_mid_dm_ack", 32'(bus.dm_ack), 0);
    chk("rst_mid_bus_err", 32'(bus.bus_err), 0);
    dm_q.delete(); if_q.delete();
    bus.dm_mr = 0; bus.dm_mw = 0; bus.if_req = 0; bus.mem_ready = 0;
    model_reset(); bc = 0;
    @(posedge clk); #5 rst = 0;
    snap();
    rdy_mode = 0;
    dev_mem[28] = 32'h600DF00D; ref_mem[28] = 32'h600DF00D;
    dm_q.push_back('{0, 32'h70, 32'h0});
    drain(20);
    chk("post_rst_latency", 32'(dm_lat), 2);
    chk("post_rst_rdata", bus.dm_rdata, 32'h600DF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
